// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the {red, yellow, green} outputs of a traffic-light controller,
// locks onto the R->G->Y sequence, counts completed cycles and latches the
// first fault it sees (one-hot, order, or dwell) until clr_err or reset.
// Optional feature macro: TLM_DWELL_CHECK_EN enables dwell-time checking.
// There is no handshake: the light inputs are sampled on every rising edge.
module traffic_light_monitor #(
    parameter int RED_CYC    = 5,
    parameter int GREEN_CYC  = 4,
    parameter int YELLOW_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [15:0]      cycles,
    output logic [CNT_W-1:0] dwell,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_RED    = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    // Light patterns in {red, yellow, green} order.
    localparam logic [2:0] PAT_R = 3'b100;
    localparam logic [2:0] PAT_Y = 3'b010;
    localparam logic [2:0] PAT_G = 3'b001;

    localparam logic [1:0] CODE_NONE  = 2'd0;
    localparam logic [1:0] CODE_ONEHOT = 2'd1;
    localparam logic [1:0] CODE_ORDER = 2'd2;
    localparam logic [1:0] CODE_DWELL = 2'd3;

    localparam logic [CNT_W-1:0] RED_D    = CNT_W'(RED_CYC);
    localparam logic [CNT_W-1:0] GREEN_D  = CNT_W'(GREEN_CYC);
    localparam logic [CNT_W-1:0] YELLOW_D = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};

`ifdef TLM_DWELL_CHECK_EN
    localparam bit DWELL_CHK = 1'b1;
`else
    localparam bit DWELL_CHK = 1'b0;
`endif

    state_t           state, state_n;
    logic [1:0]       code_q, code_n;
    logic [15:0]      cycles_q, cycles_n;
    logic [CNT_W-1:0] dwell_q, dwell_n;
    logic [2:0]       prev_q;

    logic [2:0]       pat;
    logic             one_hot;
    logic [2:0]       own_pat;
    logic [2:0]       succ_pat;
    state_t           succ_state;
    logic [CNT_W-1:0] own_cyc;

    assign pat     = {red, yellow, green};
    assign one_hot = (pat == PAT_R) || (pat == PAT_Y) || (pat == PAT_G);

    // Register state, first fault code, cycle count, dwell and last sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_SYNC;
            code_q   <= CODE_NONE;
            cycles_q <= 16'd0;
            dwell_q  <= '0;
            prev_q   <= 3'b000;
        end else begin
            state    <= state_n;
            code_q   <= code_n;
            cycles_q <= cycles_n;
            dwell_q  <= dwell_n;
            prev_q   <= pat;
        end
    end

    // Per-state expectations: own pattern, legal successor, expected dwell.
    always_comb begin
        own_pat    = PAT_R;
        succ_pat   = PAT_G;
        succ_state = S_GREEN;
        own_cyc    = RED_D;
        case (state)
            S_GREEN: begin
                own_pat    = PAT_G;
                succ_pat   = PAT_Y;
                succ_state = S_YELLOW;
                own_cyc    = GREEN_D;
            end
            S_YELLOW: begin
                own_pat    = PAT_Y;
                succ_pat   = PAT_R;
                succ_state = S_RED;
                own_cyc    = YELLOW_D;
            end
            default: begin
                own_pat    = PAT_R;
                succ_pat   = PAT_G;
                succ_state = S_GREEN;
                own_cyc    = RED_D;
            end
        endcase
    end

    // Next-state logic; fault checks ranked one-hot > order > dwell,
    // and clr_err overrides everything. FAULT holds all counters.
    always_comb begin
        state_n  = state;
        code_n   = code_q;
        cycles_n = cycles_q;
        dwell_n  = dwell_q;
        if (clr_err) begin
            state_n = S_SYNC;
            code_n  = CODE_NONE;
            dwell_n = '0;
        end else begin
            case (state)
                S_SYNC: begin
                    if (prev_q == PAT_R && pat == PAT_G) begin
                        state_n = S_GREEN;
                        dwell_n = DWELL_ONE;
                    end
                end
                S_RED, S_GREEN, S_YELLOW: begin
                    if (!one_hot) begin
                        state_n = S_FAULT;
                        code_n  = CODE_ONEHOT;
                    end else if (pat == own_pat) begin
                        if (DWELL_CHK && dwell_q == own_cyc) begin
                            state_n = S_FAULT;
                            code_n  = CODE_DWELL;
                        end else if (dwell_q != DWELL_MAX) begin
                            dwell_n = dwell_q + DWELL_ONE;
                        end
                    end else if (pat == succ_pat) begin
                        if (DWELL_CHK && dwell_q != own_cyc) begin
                            state_n = S_FAULT;
                            code_n  = CODE_DWELL;
                        end else begin
                            state_n = succ_state;
                            dwell_n = DWELL_ONE;
                            if (state == S_YELLOW && cycles_q != 16'hFFFF)
                                cycles_n = cycles_q + 16'd1;
                        end
                    end else begin
                        state_n = S_FAULT;
                        code_n  = CODE_ORDER;
                    end
                end
                S_FAULT: begin
                    state_n = S_FAULT;
                end
                default: begin
                    state_n = S_SYNC;
                end
            endcase
        end
    end

    // Output decode from the registered state and counters.
    always_comb begin
        phase = 2'd3;
        case (state)
            S_RED:    phase = 2'd0;
            S_GREEN:  phase = 2'd1;
            S_YELLOW: phase = 2'd2;
            default:  phase = 2'd3;
        endcase
    end

    assign locked    = (state == S_RED) || (state == S_GREEN) || (state == S_YELLOW);
    assign error     = (state == S_FAULT);
    assign err_code  = code_q;
    assign cycles    = cycles_q;
    assign dwell     = dwell_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with hand-computed expectations.
// Expectations for dwell faults follow TLM_DWELL_CHECK_EN at compile time.
module tb_traffic_light_monitor;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic        clk;
    logic        reset;
    logic        red, yellow, green, clr_err;
    logic [1:0]  phase;
    logic        locked, error;
    logic [1:0]  err_code;
    logic [15:0] cycles;
    logic [7:0]  dwell;
    logic [2:0]  fsm_state;

    int total;
    int bad;

    traffic_light_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .red       (red),
        .yellow    (yellow),
        .green     (green),
        .clr_err   (clr_err),
        .phase     (phase),
        .locked    (locked),
        .error     (error),
        .err_code  (err_code),
        .cycles    (cycles),
        .dwell     (dwell),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // drive one sample, let the edge take it, settle past the edge
    task automatic step(input logic [2:0] p, input logic c);
        {red, yellow, green} = p;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) step(p, 1'b0);
    endtask

    logic [2:0] stream [11];

    initial begin
        total = 0;
        bad   = 0;
        stream = '{Y, Y, R, R, R, R, R, G, G, G, G};
        reset = 1'b0;
        {red, yellow, green} = OFF;
        clr_err = 1'b0;
        #12;
        check("rst_phase",  phase, 3);
        check("rst_locked", locked, 0);
        check("rst_error",  error, 0);
        check("rst_code",   err_code, 0);
        check("rst_cycles", cycles, 0);
        check("rst_dwell",  dwell, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // sync needs red-only immediately before green-only
        step(Y, 1'b0);
        step(G, 1'b0);
        check("sync_no_lock", locked, 0);
        step(R, 1'b0);
        step(G, 1'b0);
        check("lock_phase", phase, 1);
        check("lock_dwell", dwell, 1);

        // legal R5 G4 Y2 stream
        run(G, 3);
        check("g_dwell4", dwell, 4);
        run(Y, 2);
        check("y_phase", phase, 2);
        check("y_dwell2", dwell, 2);
        step(R, 1'b0);
        check("cyc1", cycles, 1);
        run(R, 4);
        check("r_dwell5", dwell, 5);
        run(G, 4);
        run(Y, 2);
        run(R, 5);
        check("cyc2", cycles, 2);
        check("legal_err", error, 0);
        check("legal_lock", locked, 1);

        // green held one sample too long
        run(G, 4);
        check("g4_phase", phase, 1);
        step(G, 1'b0);
`ifdef TLM_DWELL_CHECK_EN
        check("dw_err",   error, 1);
        check("dw_code",  err_code, 3);
        check("dw_phase", phase, 3);
`else
        check("dw_noerr", error, 0);
        check("dw_dwell", dwell, 5);
        check("dw_phase", phase, 1);
`endif
        step(R, 1'b1);
        check("clr_phase", phase, 3);
        check("clr_err",   error, 0);
        check("clr_dwell", dwell, 0);
        check("clr_cyc",   cycles, 2);

        // order fault from RED, later faults keep first code
        step(G, 1'b0);
        run(G, 3);
        run(Y, 2);
        step(R, 1'b0);
        check("cyc3", cycles, 3);
        step(Y, 1'b0);
        check("ord_err",  error, 1);
        check("ord_code", err_code, 2);
        check("ord_lock", locked, 0);
        step(3'b101, 1'b0);
        check("ord_sticky", err_code, 2);
        check("ord_dwell_hold", dwell, 1);

        // clr_err with illegal pattern, then relock
        step(3'b111, 1'b1);
        check("clr2_phase", phase, 3);
        check("clr2_err",   error, 0);
        check("clr2_code",  err_code, 0);
        check("clr2_cyc",   cycles, 3);
        step(R, 1'b0);
        step(G, 1'b0);
        check("relock", phase, 1);

        // red+green together -> one-hot fault, sticky through legal stream
        run(G, 3);
        step(3'b101, 1'b0);
        check("oh_code", err_code, 1);
        check("oh_err",  error, 1);
        for (int i = 0; i < 20; i++) step(stream[i % 11], 1'b0);
        check("oh_sticky_err",  error, 1);
        check("oh_sticky_code", err_code, 1);
        check("oh_cyc_hold",    cycles, 3);
        check("oh_dwell_hold",  dwell, 4);

        // all-off while locked
        step(R, 1'b1);
        step(G, 1'b0);
        step(OFF, 1'b0);
        check("off_code", err_code, 1);

        // asynchronous reset pulse mid-GREEN
        step(R, 1'b1);
        step(G, 1'b0);
        step(G, 1'b0);
        check("pre_rst_dwell", dwell, 2);
        #2 reset = 1'b0;
        #1;
        check("arst_phase",  phase, 3);
        check("arst_locked", locked, 0);
        check("arst_cycles", cycles, 0);
        check("arst_dwell",  dwell, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_sync", phase, 3);
        step(R, 1'b0);
        step(G, 1'b0);
        check("post_rst_lock", phase, 1);
        check("post_rst_cyc",  cycles, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter RED_CYC, default 5, expected red dwell in clock cycles.
REQ-002 SHALL have parameter GREEN_CYC, default 4, expected green dwell in clock cycles.
REQ-003 SHALL have parameter YELLOW_CYC, default 2, expected yellow dwell in clock cycles.
REQ-004 SHALL have parameter CNT_W, default 8, dwell counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports red, yellow, green  input  1 each  observed light outputs of the controller.
REQ-008 SHALL have port clr_err  input  1  clears sticky error and returns to SYNC.
REQ-009 SHALL have port phase  output  2  0=RED, 1=GREEN, 2=YELLOW, 3=SYNC/FAULT.
REQ-010 SHALL have port locked  output  1  high in RED, GREEN or YELLOW state.
REQ-011 SHALL have port error  output  1  sticky fault flag.
REQ-012 SHALL have port err_code  output  2  first fault: 0 none, 1 one-hot, 2 order, 3 dwell.
REQ-013 SHALL have port cycles  output  16  count of completed legal R-G-Y cycles.
REQ-014 SHALL have port dwell  output  CNT_W  consecutive samples in current light state.

Function
REQ-015 SHALL sample {red,yellow,green} on every rising clk edge; all outputs registered and updated on that same edge (error visible one edge after the offending pattern is present).
REQ-016 SHALL implement states SYNC, RED, GREEN, YELLOW, FAULT.
REQ-017 SYNC: no faults flagged; on a sample of green-only immediately following a red-only sample, SHALL enter GREEN with dwell=1.
REQ-018 Locked states: pattern unchanged -> dwell increments, saturating at all-ones.
REQ-019 Legal transitions only RED->GREEN, GREEN->YELLOW, YELLOW->RED; on legal change dwell SHALL reload to 1.
REQ-020 Any locked-state sample not exactly one-hot (all-off or multiple on) SHALL enter FAULT with err_code=1.
REQ-021 Any locked-state change to a one-hot pattern other than the legal successor SHALL enter FAULT with err_code=2.
REQ-022 One-hot check SHALL take priority over order and dwell checks in the same cycle; order over dwell.
REQ-023 On YELLOW->RED transition with no fault, cycles SHALL increment by 1, saturating at 16'hFFFF.
REQ-024 FAULT: error=1, phase=3, locked=0, err_code held, dwell held, cycles held; exit only via clr_err or reset.
REQ-025 clr_err=1 SHALL, from any state, force SYNC, error=0, err_code=0, dwell=0 next edge; cycles unchanged; clr_err wins over a simultaneous fault.
REQ-026 err_code SHALL record only the first fault after reset/clr_err.

Reset
REQ-027 reset low SHALL immediately (asynchronously) force state SYNC, phase=3, locked=0, error=0, err_code=0, cycles=0, dwell=0, including mid-cycle.
REQ-028 After reset deasserts, operation SHALL resume on the next rising clk edge, starting in SYNC.

Configuration
REQ-029 Macro TLM_DWELL_CHECK_EN SHALL, when defined, compile in dwell checking: legal change out of state X with dwell != X_CYC, or dwell reaching X_CYC+1 while still in X, enters FAULT with err_code=3 on that sample.
REQ-030 Without TLM_DWELL_CHECK_EN, dwell SHALL still count but err_code=3 SHALL never occur; any dwell is legal.

Verification (defaults, TLM_DWELL_CHECK_EN defined unless stated)
REQ-031 Stream R5,G4,Y2 repeated after one R->G sync -> error=0, locked=1, cycles increments by 1 every 11 cycles, dwell peaks 5/4/2.
REQ-032 Green held 5 samples -> edge sampling 5th green: error=1, err_code=3, phase=3; without macro: no error, dwell=5.
REQ-033 Locked in RED, input goes yellow-only -> error=1, err_code=2; subsequent one-hot faults do not change err_code.
REQ-034 Locked, red=1 and green=1 together -> err_code=1 (not 2 or 3), error sticky for 20 cycles of legal stream.
REQ-035 In FAULT, clr_err=1 coincident with illegal pattern -> next edge phase=3, error=0, err_code=0, cycles retained; relocks on next R->G.
REQ-036 reset low for 3 ns mid-GREEN between clk edges -> outputs at reset values before next edge; cycles=0.
